fetch_unit: RTL and testbench

//  Instruction fetch stage of Core101. Holds the PC, issues one-outstanding

---
 rtl/core101_pkg.sv | 16 +
 rtl/fetch_out_slot.sv | 39 +++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_pkg.sv
// Shared definitions for the Core101 fetch stage: FSM encodings,
// the NOP used to fill an empty instruction slot, and default parameters.
package core101_pkg;

  localparam int unsigned       XLEN               = 32;
  localparam logic [XLEN-1:0]   NOP_INSN           = 32'h00000013;
  localparam logic [XLEN-1:0]   DEFAULT_RESET_ADDR = 32'h00000000;
  localparam int unsigned       DEFAULT_PC_INC     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_slot.sv
// One-entry instruction buffer between fetch and decode.
// clear (redirect) beats load, load beats drain; a load in the same cycle
// as a drain simply replaces the departing entry.
module fetch_out_slot
  import core101_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_ADDR = '0
) (
  input  logic                  clk_sys,
  input  logic                  rst_b,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  drain,
  input  logic [DATA_WIDTH-1:0] load_ir,
  input  logic [DATA_WIDTH-1:0] load_pc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] pc
);

  // slot register: ir/pc only change on load so they stay stable under backpressure
  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      valid <= 1'b0;
      ir    <= DATA_WIDTH'(NOP_INSN);
      pc    <= RESET_ADDR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      ir    <= load_ir;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Core101 instruction fetch: PC, single-outstanding memory read FSM and
// the IF/ID output slot.
//
//  state | meaning
//  IDLE  | no read outstanding
//  REQ   | read of mem_addr_out (== pc) outstanding, word will be kept
//  DROP  | read outstanding but made stale by a redirect; word discarded
//
// An ack that arrives while the slot is full and decode is not draining it
// cannot be stored. That word is dropped without advancing pc and the FSM
// idles, so the same address is fetched again once decode frees the slot.
module fetch_unit
  import core101_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter int unsigned            PC_INC     = DEFAULT_PC_INC
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  halt_in,
  input  logic                  redirect_valid_in,
  input  logic [DATA_WIDTH-1:0] redirect_addr_in,
  output logic                  mem_read_out,
  output logic [DATA_WIDTH-1:0] mem_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_valid_in,
  input  logic                  id_ready_in,
  output logic                  ir_valid_out,
  output logic [DATA_WIDTH-1:0] ir_data_out,
  output logic [DATA_WIDTH-1:0] pc_addr_out,
  output logic                  misaligned_out
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(PC_INC);

  fetch_state_e           state, state_n;
  logic [DATA_WIDTH-1:0]  pc, pc_n;
  logic [DATA_WIDTH-1:0]  mem_addr_n;
  logic                   mem_read_n;
  logic                   misaligned_n;
  logic [DATA_WIDTH-1:0]  redir_pc;
  logic [DATA_WIDTH-1:0]  seq_pc;
  logic                   slot_room;
  logic                   can_req;
  logic                   slot_load;
  logic                   slot_drain;

  assign slot_room  = !ir_valid_out || id_ready_in;
  assign can_req    = !halt_in && slot_room;
  assign slot_drain = ir_valid_out && id_ready_in;
  assign redir_pc   = {redirect_addr_in[DATA_WIDTH-1:2], 2'b00};
  assign seq_pc     = pc + PC_STEP;

  // state, pc and memory-request registers
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state          <= ST_IDLE;
      pc             <= RESET_ADDR;
      mem_read_out   <= 1'b0;
      mem_addr_out   <= RESET_ADDR;
      misaligned_out <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      mem_read_out   <= mem_read_n;
      mem_addr_out   <= mem_addr_n;
      misaligned_out <= misaligned_n;
    end
  end

  // next-state, next-pc and request decisions; redirect has top priority
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    mem_read_n   = mem_read_out;
    mem_addr_n   = mem_addr_out;
    slot_load    = 1'b0;
    misaligned_n = redirect_valid_in && (redirect_addr_in[1:0] != 2'b00);

    unique case (state)
      ST_IDLE: begin
        if (redirect_valid_in) pc_n = redir_pc;
        if (can_req) begin
          state_n    = ST_REQ;
          mem_read_n = 1'b1;
          mem_addr_n = redirect_valid_in ? redir_pc : pc;
        end
      end

      ST_REQ: begin
        if (redirect_valid_in) begin
          pc_n = redir_pc;
          if (!mem_valid_in) begin
            state_n = ST_DROP;
          end else if (can_req) begin
            mem_addr_n = redir_pc;
          end else begin
            state_n    = ST_IDLE;
            mem_read_n = 1'b0;
          end
        end else if (mem_valid_in) begin
          if (slot_room) begin
            slot_load = 1'b1;
            pc_n      = seq_pc;
            if (can_req) begin
              mem_addr_n = seq_pc;
            end else begin
              state_n    = ST_IDLE;
              mem_read_n = 1'b0;
            end
          end else begin
            state_n    = ST_IDLE;
            mem_read_n = 1'b0;
          end
        end
      end

      ST_DROP: begin
        if (redirect_valid_in) pc_n = redir_pc;
        if (mem_valid_in) begin
          if (can_req) begin
            state_n    = ST_REQ;
            mem_addr_n = redirect_valid_in ? redir_pc : pc;
          end else begin
            state_n    = ST_IDLE;
            mem_read_n = 1'b0;
          end
        end
      end

      default: begin
        state_n    = ST_IDLE;
        mem_read_n = 1'b0;
      end
    endcase
  end

  fetch_out_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_slot (
    .clk_sys (clock_in),
    .rst_b   (reset_in),
    .load    (slot_load),
    .clear   (redirect_valid_in),
    .drain   (slot_drain),
    .load_ir (mem_data_in),
    .load_pc (mem_addr_out),
    .valid   (ir_valid_out),
    .ir      (ir_data_out),
    .pc      (pc_addr_out)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a behavioural instruction memory
// with programmable latency, and a scoreboard of expected deliveries that a
// separate monitor checks on every IF/ID transfer.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock_in;
  logic        reset_in;
  logic        halt_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_addr_in;
  logic        mem_read_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_in;
  logic        mem_valid_in;
  logic        id_ready_in;
  logic        ir_valid_out;
  logic [31:0] ir_data_out;
  logic [31:0] pc_addr_out;
  logic        misaligned_out;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } deliv_t;

  deliv_t sb[$];
  int     total = 0;
  int     bad   = 0;
  int     mem_lat = 0;

  fetch_unit dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .halt_in           (halt_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_addr_in  (redirect_addr_in),
    .mem_read_out      (mem_read_out),
    .mem_addr_out      (mem_addr_out),
    .mem_data_in       (mem_data_in),
    .mem_valid_in      (mem_valid_in),
    .id_ready_in       (id_ready_in),
    .ir_valid_out      (ir_valid_out),
    .ir_data_out       (ir_data_out),
    .pc_addr_out       (pc_addr_out),
    .misaligned_out    (misaligned_out)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int count);
    for (int i = 0; i < count; i++) begin
      deliv_t d;
      d.pc = start + 32'(4 * i);
      d.ir = d.pc ^ KEY;
      sb.push_back(d);
    end
  endtask

  task automatic tick();
    @(negedge clock_in);
  endtask

  // instruction memory: acks after mem_lat wait cycles, data = addr ^ KEY
  initial begin
    int busy;
    busy         = 0;
    mem_valid_in = 1'b0;
    mem_data_in  = 32'h0;
    forever begin
      @(negedge clock_in);
      if (mem_read_out) begin
        if (busy >= mem_lat) begin
          mem_valid_in = 1'b1;
          mem_data_in  = mem_addr_out ^ KEY;
          busy         = 0;
        end else begin
          mem_valid_in = 1'b0;
          busy++;
        end
      end else begin
        mem_valid_in = 1'b0;
        busy         = 0;
      end
    end
  end

  // monitor: every IF/ID transfer must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clock_in);
      #2;
      if (reset_in && ir_valid_out && id_ready_in) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery: got pc %h want none", pc_addr_out);
        end else begin
          deliv_t e;
          e = sb.pop_front();
          chk("deliver_pc", pc_addr_out, e.pc);
          chk("deliver_ir", ir_data_out, e.ir);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset_in          = 1'b0;
    halt_in           = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_addr_in  = 32'h0;
    id_ready_in       = 1'b0;

    // reset held for three edges
    repeat (3) tick();
    chk("rst_mem_read",   32'(mem_read_out),   32'h0);
    chk("rst_mem_addr",   mem_addr_out,        32'h0);
    chk("rst_ir_valid",   32'(ir_valid_out),   32'h0);
    chk("rst_ir_data",    ir_data_out,         NOP);
    chk("rst_pc_addr",    pc_addr_out,         32'h0);
    chk("rst_misaligned", 32'(misaligned_out), 32'h0);
    reset_in    = 1'b1;
    id_ready_in = 1'b1;
    push_seq(32'h0, 12);

    // first request the cycle after release
    tick();
    chk("first_req_read", 32'(mem_read_out), 32'h1);
    chk("first_req_addr", mem_addr_out,      32'h0);

    // zero-wait streaming
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_valid", 32'(ir_valid_out), 32'h1);
    end

    // backpressure: slot holds pc 0x20 for five cycles
    tick();
    id_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_mem_read", 32'(mem_read_out), 32'h0);
      chk("bp_valid",    32'(ir_valid_out), 32'h1);
      chk("bp_pc",       pc_addr_out,       32'h20);
      chk("bp_ir",       ir_data_out,       32'h20 ^ KEY);
    end
    tick();
    id_ready_in = 1'b1;
    tick();
    chk("resume_read", 32'(mem_read_out), 32'h1);
    chk("resume_addr", mem_addr_out,      32'h24);

    // halt with zero-wait memory
    tick();
    halt_in = 1'b1;
    tick();
    chk("halt_read_off", 32'(mem_read_out), 32'h0);
    tick();
    chk("halt_idle_read",  32'(mem_read_out), 32'h0);
    chk("halt_idle_valid", 32'(ir_valid_out), 32'h0);
    halt_in = 1'b0;
    tick();
    chk("unhalt_read", 32'(mem_read_out), 32'h1);
    chk("unhalt_addr", mem_addr_out,      32'h2C);
    halt_in = 1'b1;
    tick();
    chk("halt2_read_off", 32'(mem_read_out), 32'h0);
    mem_lat = 3;
    push_seq(32'h200, 2);

    // slow memory, redirect in second wait cycle
    tick();
    halt_in = 1'b0;
    tick();
    chk("slow_req_addr", mem_addr_out, 32'h30);
    tick();
    redirect_valid_in = 1'b1;
    redirect_addr_in  = 32'h200;
    tick();
    redirect_valid_in = 1'b0;
    chk("drop_read_held", 32'(mem_read_out), 32'h1);
    chk("drop_addr_held", mem_addr_out,      32'h30);
    tick();
    tick();
    chk("redir_read",  32'(mem_read_out), 32'h1);
    chk("redir_addr",  mem_addr_out,      32'h200);
    chk("redir_empty", 32'(ir_valid_out), 32'h0);
    repeat (3) tick();
    tick();
    chk("redir_word_valid", 32'(ir_valid_out), 32'h1);
    chk("redir_word_pc",    pc_addr_out,       32'h200);

    // halt raised while a slow request is outstanding
    tick();
    halt_in = 1'b1;
    repeat (2) tick();
    tick();
    chk("halt_slow_read",  32'(mem_read_out), 32'h0);
    chk("halt_slow_valid", 32'(ir_valid_out), 32'h1);
    chk("halt_slow_pc",    pc_addr_out,       32'h204);
    tick();
    chk("halted_valid", 32'(ir_valid_out), 32'h0);
    chk("halted_read",  32'(mem_read_out), 32'h0);
    redirect_valid_in = 1'b1;
    redirect_addr_in  = 32'hFFFF_FFFC;
    tick();
    redirect_valid_in = 1'b0;
    chk("halted_redir_read", 32'(mem_read_out), 32'h0);
    mem_lat = 0;
    halt_in = 1'b0;
    push_seq(32'hFFFF_FFFC, 2);

    // wrap-around
    tick();
    chk("wrap_req_read", 32'(mem_read_out), 32'h1);
    chk("wrap_req_addr", mem_addr_out,      32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr", mem_addr_out, 32'h0);

    // misaligned redirect, coinciding with an ack and a transfer
    tick();
    redirect_valid_in = 1'b1;
    redirect_addr_in  = 32'h102;
    push_seq(32'h100, 2);
    tick();
    redirect_valid_in = 1'b0;
    chk("misal_pulse", 32'(misaligned_out), 32'h1);
    chk("misal_addr",  mem_addr_out,        32'h100);
    chk("misal_empty", 32'(ir_valid_out),   32'h0);
    tick();
    chk("misal_clear", 32'(misaligned_out), 32'h0);
    halt_in = 1'b1;
    tick();
    chk("final_read_off", 32'(mem_read_out), 32'h0);
    repeat (3) tick();
    #3;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
